// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receive path: FSM states,
// default frame geometry and the mid-bit sample positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int OSR_DEF       = 16;
    localparam int DATA_BITS_DEF = 8;

    // Three samples straddle the bit centre at OSR/2.
    function automatic int samp_lo(input int osr);
        return osr / 2 - 1;
    endfunction

    function automatic int samp_mid(input int osr);
        return osr / 2;
    endfunction

    function automatic int samp_hi(input int osr);
        return osr / 2 + 1;
    endfunction

    localparam int SAMP_LO_DEF  = OSR_DEF / 2 - 1;
    localparam int SAMP_MID_DEF = OSR_DEF / 2;
    localparam int SAMP_HI_DEF  = OSR_DEF / 2 + 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input that idles high; both
// stages reset to 1 so no spurious low is seen after reset.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver: 3-sample mid-bit majority, false-start
// rejection, frame-error flag and a valid/ack output register with overrun.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int OSR       = OSR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 serial_in,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OSR);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [CW-1:0] S_LO     = CW'(samp_lo(OSR));
    localparam logic [CW-1:0] S_MID    = CW'(samp_mid(OSR));
    localparam logic [CW-1:0] S_HI     = CW'(samp_hi(OSR));
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_e               state_q;
    logic [CW-1:0]        os_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 samp0_q;
    logic                 samp1_q;
    logic                 vote_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
    logic                 maj_d;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    // The third sample is taken live, so the vote is valid on the S_HI tick.
    assign maj_d = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            samp0_q     <= 1'b1;
            samp1_q     <= 1'b1;
            vote_q      <= 1'b1;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (rd_ack && valid_q) begin
                valid_q <= 1'b0;
            end

            if (tick) begin
                if (state_q != IDLE) begin
                    os_cnt_q <= (os_cnt_q == CNT_LAST) ? '0 : os_cnt_q + 1'b1;
                    if (os_cnt_q == S_LO)  samp0_q <= rx_s;
                    if (os_cnt_q == S_MID) samp1_q <= rx_s;
                    if (os_cnt_q == S_HI)  vote_q  <= maj_d;
                end

                unique case (state_q)
                    IDLE: begin
                        // The detecting tick is position 0 of the start bit.
                        if (!rx_s) begin
                            state_q  <= START;
                            os_cnt_q <= CW'(1);
                            busy_q   <= 1'b1;
                        end
                    end
                    START: begin
                        if (os_cnt_q == CNT_LAST) begin
                            if (vote_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (os_cnt_q == CNT_LAST) begin
                            shift_q <= {vote_q, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        // Decide early so the next start edge is not missed.
                        if (os_cnt_q == S_HI) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            os_cnt_q <= '0;
                            if (maj_d) begin
                                data_q    <= shift_q;
                                valid_q   <= 1'b1;
                                overrun_q <= valid_q && !rd_ack;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign parallel_out = data_q;
    assign valid        = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule
